// File: rtl/ntt_gf64_pmr.sv
// Partial modular reduction modulo the Solinas prime 2^W - 2^(W/2) + 1.
// Folds a wide signed operand into a W+2-bit signed congruent value; side-band tracks latency.
module ntt_gf64_pmr #(
  parameter int unsigned OP_W      = 67,
  parameter int unsigned MOD_NTT_W = 64,
  parameter int unsigned IN_PIPE   = 1,
  parameter int unsigned SIDE_W    = 67,
  parameter logic [1:0]  RST_SIDE  = 2'b01
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic [OP_W-1:0]        a,
  input  logic                   in_avail,
  input  logic [SIDE_W-1:0]      in_side,
  output logic [MOD_NTT_W+1:0]   z,
  output logic                   out_avail,
  output logic [SIDE_W-1:0]      out_side
);

  localparam int unsigned W  = MOD_NTT_W;
  localparam int unsigned H  = OP_W - W;
  localparam int unsigned ZW = W + 2;

  logic [OP_W-1:0]   w_a;
  logic              w_avail;
  logic [SIDE_W-1:0] w_side;

  generate
    if (IN_PIPE != 0) begin : g_in_pipe
      logic [OP_W-1:0]   r_a;
      logic              r_avail;
      logic [SIDE_W-1:0] r_side;

      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) r_avail <= 1'b0;
        else       r_avail <= in_avail;
      end

      always_ff @(posedge clk) begin
        if (in_avail) r_a <= a;
      end

      if (RST_SIDE[0]) begin : g_side_rst
        always_ff @(posedge clk or posedge a_rst) begin
          if (a_rst)         r_side <= '0;
          else if (in_avail) r_side <= in_side;
        end
      end else begin : g_side_nrst
        always_ff @(posedge clk) begin
          if (in_avail) r_side <= in_side;
        end
      end

      assign w_a     = r_a;
      assign w_avail = r_avail;
      assign w_side  = r_side;
    end else begin : g_no_pipe
      assign w_a     = a;
      assign w_avail = in_avail;
      assign w_side  = in_side;
    end
  endgenerate

  // 2^W == 2^(W/2) - 1 (mod p), so the high part folds in as hi*2^(W/2) - hi.
  logic signed [ZW-1:0] w_lo;
  logic signed [ZW-1:0] w_hi;
  logic signed [ZW-1:0] w_z;

  always_comb begin
    w_lo = {2'b00, w_a[W-1:0]};
    w_hi = {{(ZW-H){w_a[OP_W-1]}}, w_a[OP_W-1:W]};
    w_z  = w_lo + (w_hi <<< (W/2)) - w_hi;
  end

  logic [ZW-1:0]     r_z;
  logic              r_out_avail;
  logic [SIDE_W-1:0] r_out_side;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) r_out_avail <= 1'b0;
    else       r_out_avail <= w_avail;
  end

  always_ff @(posedge clk) begin
    if (w_avail) r_z <= w_z;
  end

  generate
    if (RST_SIDE[1]) begin : g_oside_rst
      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst)        r_out_side <= '0;
        else if (w_avail) r_out_side <= w_side;
      end
    end else begin : g_oside_nrst
      always_ff @(posedge clk) begin
        if (w_avail) r_out_side <= w_side;
      end
    end
  endgenerate

  assign z         = r_z;
  assign out_avail = r_out_avail;
  assign out_side  = r_out_side;

endmodule

// File: tb/tb_ntt_gf64_pmr.sv
// Scoreboarded random and directed bench for ntt_gf64_pmr; two instances share the stimulus
// (IN_PIPE=1 with default side reset, IN_PIPE=0 with both side registers reset).
module tb_ntt_gf64_pmr;

  localparam int unsigned OP_W   = 67;
  localparam int unsigned W      = 64;
  localparam int unsigned SIDE_W = 67;

  localparam logic signed [127:0] P      = 128'sh0000_0000_0000_0000_FFFF_FFFF_0000_0001;
  localparam logic signed [127:0] K      = 128'sh0000_0000_0000_0000_0000_0000_FFFF_FFFF;
  localparam logic signed [127:0] Z_LO   = -(128'sd4 * K);
  localparam logic signed [127:0] Z_HI   = (128'sd1 <<< 64) + 128'sd3 * K;

  logic              clk = 1'b0;
  logic              a_rst = 1'b1;
  logic [OP_W-1:0]   a = '0;
  logic              in_avail = 1'b0;
  logic [SIDE_W-1:0] in_side = '0;

  logic [W+1:0]      z0, z1;
  logic              out_avail0, out_avail1;
  logic [SIDE_W-1:0] out_side0, out_side1;

  always #5 clk = ~clk;

  ntt_gf64_pmr #(
    .OP_W(OP_W), .MOD_NTT_W(W), .IN_PIPE(1), .SIDE_W(SIDE_W), .RST_SIDE(2'b01)
  ) u_dut0 (
    .clk(clk), .a_rst(a_rst), .a(a), .in_avail(in_avail), .in_side(in_side),
    .z(z0), .out_avail(out_avail0), .out_side(out_side0)
  );

  ntt_gf64_pmr #(
    .OP_W(OP_W), .MOD_NTT_W(W), .IN_PIPE(0), .SIDE_W(SIDE_W), .RST_SIDE(2'b11)
  ) u_dut1 (
    .clk(clk), .a_rst(a_rst), .a(a), .in_avail(in_avail), .in_side(in_side),
    .z(z1), .out_avail(out_avail1), .out_side(out_side1)
  );

  typedef struct {
    logic signed [127:0] a;
    logic signed [127:0] z;
    logic [SIDE_W-1:0]   side;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: floor-split a = hi*2^64 + lo, then replace 2^64 by 2^32 - 1.
  function automatic logic signed [127:0] ref_fold(input logic signed [127:0] av);
    logic signed [127:0] hi, lo;
    hi = av >>> 64;
    lo = av - (hi <<< 64);
    return lo + hi * K;
  endfunction

  function automatic logic signed [127:0] sext_a(input logic [OP_W-1:0] v);
    logic signed [OP_W-1:0] s;
    s = v;
    return s;
  endfunction

  function automatic logic signed [127:0] sext_z(input logic [W+1:0] v);
    logic signed [W+1:0] s;
    s = v;
    return s;
  endfunction

  task automatic check_out(input int id, input logic [W+1:0] zv, input logic [SIDE_W-1:0] sv);
    exp_t e;
    logic signed [127:0] zs, diff;
    string tag;
    tag = (id == 0) ? "pipe1" : "pipe0";
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      chk({tag, " unexpected_out_avail"}, 128'd1, 128'd0);
      return;
    end
    e  = (id == 0) ? q0.pop_front() : q1.pop_front();
    zs = sext_z(zv);
    chk({tag, " z"}, zs, e.z);
    chk({tag, " out_side"}, {61'd0, sv}, {61'd0, e.side});
    diff = zs - e.a;
    chk({tag, " congruence"}, diff % P, 128'd0);
    chk({tag, " range"}, {127'd0, (zs >= Z_LO) && (zs < Z_HI)}, 128'd1);
  endtask

  // Monitor: in_avail history tracks expected out_avail for both latencies.
  logic [1:0] hist = 2'b00;

  always @(negedge clk) begin
    if (a_rst) begin
      chk("out_avail_in_reset pipe1", {127'd0, out_avail0}, 128'd0);
      chk("out_avail_in_reset pipe0", {127'd0, out_avail1}, 128'd0);
      chk("out_side_in_reset pipe0", {61'd0, out_side1}, 128'd0);
      hist = 2'b00;
    end else begin
      chk("out_avail_latency2", {127'd0, out_avail0}, {127'd0, hist[1]});
      chk("out_avail_latency1", {127'd0, out_avail1}, {127'd0, hist[0]});
      if (out_avail0) check_out(0, z0, out_side0);
      if (out_avail1) check_out(1, z1, out_side1);
      hist = {hist[0], in_avail};
    end
  end

  task automatic step(input logic rst, input logic v, input logic [OP_W-1:0] av,
                      input logic [SIDE_W-1:0] sv, input logic use_exp,
                      input logic signed [127:0] zexp);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst && !a_rst) begin
      q0.delete();
      q1.delete();
    end
    a_rst    = rst;
    a        = av;
    in_side  = sv;
    in_avail = v;
    if (v && !rst) begin
      e.a    = sext_a(av);
      e.z    = use_exp ? zexp : ref_fold(sext_a(av));
      e.side = sv;
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rand_item(input logic v);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r[66:0] = {1'b0, {66{1'b1}}};
      1: r[66:0] = {1'b1, 66'd0};
      2: r[66:64] = 3'b111;
      default: ;
    endcase
    step(1'b0, v, r[66:0], r[66:0], 1'b0, '0);
  endtask

  initial begin
    logic [OP_W-1:0] av;
    int budget;

    repeat (3) @(posedge clk);
    idle(2);

    // Directed vectors with hand-derived results.
    step(1'b0, 1'b1, '0, '0, 1'b1, 128'sd0);
    idle(3);
    av = {3'b001, 64'd0};
    step(1'b0, 1'b1, av, 67'h15, 1'b1, 128'sh0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    av = {1'b0, {66{1'b1}}};
    step(1'b0, 1'b1, av, 67'h2A, 1'b1, 128'sh0000_0000_0000_0001_0000_0002_FFFF_FFFC);
    av = '1;
    step(1'b0, 1'b1, av, 67'h3F, 1'b1, 128'sh0000_0000_0000_0000_FFFF_FFFF_0000_0000);
    av = {1'b1, 66'd0};
    step(1'b0, 1'b1, av, 67'h7, 1'b1, -128'sh3_FFFF_FFFC);
    idle(3);

    // Back-to-back random stream.
    for (int i = 0; i < 1500; i++) rand_item(1'b1);
    // Random gaps.
    for (int i = 0; i < 2500; i++) rand_item($urandom_range(0, 2) != 0);
    idle(3);

    // Reset with two items in flight, in_avail held high through reset.
    rand_item(1'b1);
    rand_item(1'b1);
    step(1'b1, 1'b1, 67'h123, 67'h456, 1'b0, '0);
    step(1'b1, 1'b1, 67'h123, 67'h456, 1'b0, '0);
    step(1'b1, 1'b1, 67'h123, 67'h456, 1'b0, '0);
    av = {3'b001, 64'd0};
    step(1'b0, 1'b1, av, 67'h99, 1'b1, 128'sh0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    idle(1);
    for (int i = 0; i < 200; i++) rand_item($urandom_range(0, 1) != 0);
    idle(1);

    budget = 20;
    while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("drain_pending_items", {96'd0, 32'(q0.size() + q1.size())}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
